// File: rtl/ea_calc.sv
// 8086 ModR/M effective-address calculator: snapshots BX/BP/SI/DI on accept,
// forms base + displacement, selects the default or override segment, holds until ack.
module ea_calc #(
   parameter int ADD_STAGE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  modrm,
   input  logic [15:0] disp,
   input  logic        seg_ovr_en,
   input  logic [1:0]  seg_ovr,
   input  logic [15:0] bx,
   input  logic [15:0] bp,
   input  logic [15:0] si,
   input  logic [15:0] di,
   input  logic        ack,
   output logic        busy,
   output logic        valid,
   output logic [15:0] ea,
   output logic [1:0]  seg,
   output logic        is_reg,
   output logic [2:0]  reg_sel
);

   // Handshake: start is taken only in IDLE. The result is presented with valid=1
   // and held unchanged until the consumer raises ack, which completes on that edge.
   typedef enum logic [1:0] {IDLE, SUM, ADD, DONE} state_t;

   localparam bit TWO_CYC = (ADD_STAGE != 0);

   state_t      state, state_next;
   logic        load_out;

   logic [1:0]  mod_q;
   logic [2:0]  rm_q;
   logic [15:0] disp_q;
   logic        ovr_en_q;
   logic [1:0]  ovr_q;
   logic [15:0] bx_q, bp_q, si_q, di_q;
   logic [15:0] base_q;

   logic [15:0] base;
   logic [15:0] disp_ext;
   logic [15:0] ea_next;
   logic [1:0]  seg_next;

   logic [15:0] ea_q;
   logic [1:0]  seg_q;
   logic        is_reg_q;
   logic [2:0]  reg_sel_q;

   // The reg field of ModR/M selects the other operand and plays no part here.
   logic        unused_reg_field;
   assign unused_reg_field = ^modrm[5:3];

   always_comb begin
      base = 16'h0000;
      case (rm_q)
         3'd0: base = bx_q + si_q;
         3'd1: base = bx_q + di_q;
         3'd2: base = bp_q + si_q;
         3'd3: base = bp_q + di_q;
         3'd4: base = si_q;
         3'd5: base = di_q;
         3'd6: base = (mod_q == 2'b00) ? 16'h0000 : bp_q;
         3'd7: base = bx_q;
         default: base = 16'h0000;
      endcase
   end

   always_comb begin
      disp_ext = 16'h0000;
      case (mod_q)
         2'b00:   disp_ext = (rm_q == 3'd6) ? disp_q : 16'h0000;
         2'b01:   disp_ext = {{8{disp_q[7]}}, disp_q[7:0]};
         2'b10:   disp_ext = disp_q;
         default: disp_ext = 16'h0000;
      endcase
   end

   // BP-based modes default to SS; the mod00 rm110 direct form has no base and stays DS.
   always_comb begin
      seg_next = 2'd3;
      if (mod_q == 2'b11)
         seg_next = 2'd3;
      else if (ovr_en_q)
         seg_next = ovr_q;
      else if (rm_q == 3'd2 || rm_q == 3'd3 || (rm_q == 3'd6 && mod_q != 2'b00))
         seg_next = 2'd2;
   end

   always_comb begin
      ea_next = 16'h0000;
      if (mod_q != 2'b11)
         ea_next = (TWO_CYC ? base_q : base) + disp_ext;
   end

   always_comb begin
      state_next = state;
      load_out   = 1'b0;
      case (state)
         IDLE: if (start) state_next = SUM;
         SUM: begin
            if (TWO_CYC) begin
               state_next = ADD;
            end else begin
               state_next = DONE;
               load_out   = 1'b1;
            end
         end
         ADD: begin
            state_next = DONE;
            load_out   = 1'b1;
         end
         DONE: if (ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mod_q     <= 2'b00;
         rm_q      <= 3'd0;
         disp_q    <= 16'h0000;
         ovr_en_q  <= 1'b0;
         ovr_q     <= 2'd0;
         bx_q      <= 16'h0000;
         bp_q      <= 16'h0000;
         si_q      <= 16'h0000;
         di_q      <= 16'h0000;
         base_q    <= 16'h0000;
         ea_q      <= 16'h0000;
         seg_q     <= 2'd3;
         is_reg_q  <= 1'b0;
         reg_sel_q <= 3'd0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            mod_q    <= modrm[7:6];
            rm_q     <= modrm[2:0];
            disp_q   <= disp;
            ovr_en_q <= seg_ovr_en;
            ovr_q    <= seg_ovr;
            bx_q     <= bx;
            bp_q     <= bp;
            si_q     <= si;
            di_q     <= di;
         end
         if (state == SUM)
            base_q <= base;
         if (load_out) begin
            ea_q      <= ea_next;
            seg_q     <= seg_next;
            is_reg_q  <= (mod_q == 2'b11);
            reg_sel_q <= rm_q;
         end
      end
   end

   assign busy    = (state != IDLE);
   assign valid   = (state == DONE);
   assign ea      = ea_q;
   assign seg     = seg_q;
   assign is_reg  = is_reg_q;
   assign reg_sel = reg_sel_q;

endmodule

// File: tb/tb_ea_calc.sv
// Bench for ea_calc: two instances (ADD_STAGE=1 and 0) share stimulus and are
// checked against an arithmetic model of 8086 ModR/M addressing.
module tb_ea_calc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  modrm = 8'h00;
   logic [15:0] disp = 16'h0000;
   logic        seg_ovr_en = 1'b0;
   logic [1:0]  seg_ovr = 2'd0;
   logic [15:0] bx = 16'h0, bp = 16'h0, si = 16'h0, di = 16'h0;
   logic        ack = 1'b0;

   logic        busy1, valid1, is_reg1;
   logic [15:0] ea1;
   logic [1:0]  seg1;
   logic [2:0]  reg_sel1;
   logic        busy0, valid0, is_reg0;
   logic [15:0] ea0;
   logic [1:0]  seg0;
   logic [2:0]  reg_sel0;

   int vectors = 0;
   int errors  = 0;

   typedef struct packed {
      logic        is_reg;
      logic [2:0]  reg_sel;
      logic [1:0]  seg;
      logic [15:0] ea;
   } exp_t;

   always #5 clk = ~clk;

   ea_calc #(.ADD_STAGE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .modrm(modrm), .disp(disp),
      .seg_ovr_en(seg_ovr_en), .seg_ovr(seg_ovr), .bx(bx), .bp(bp), .si(si), .di(di),
      .ack(ack), .busy(busy1), .valid(valid1), .ea(ea1), .seg(seg1),
      .is_reg(is_reg1), .reg_sel(reg_sel1)
   );

   ea_calc #(.ADD_STAGE(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .modrm(modrm), .disp(disp),
      .seg_ovr_en(seg_ovr_en), .seg_ovr(seg_ovr), .bx(bx), .bp(bp), .si(si), .di(di),
      .ack(ack), .busy(busy0), .valid(valid0), .ea(ea0), .seg(seg0),
      .is_reg(is_reg0), .reg_sel(reg_sel0)
   );

   // Reference: integer arithmetic on the addressing rules, reduced mod 65536 at the end.
   function automatic exp_t model(input logic [7:0] m, input logic [15:0] d,
                                  input logic oen, input logic [1:0] ov,
                                  input logic [15:0] rbx, input logic [15:0] rbp,
                                  input logic [15:0] rsi, input logic [15:0] rdi);
      exp_t r;
      int   sum;
      int   dv;
      int   md;
      int   rm;
      md = int'(m[7:6]);
      rm = int'(m[2:0]);
      r.reg_sel = m[2:0];
      if (md == 3) begin
         r.is_reg = 1'b1;
         r.ea     = 16'h0000;
         r.seg    = 2'd3;
         return r;
      end
      r.is_reg = 1'b0;
      case (rm)
         0: sum = int'(rbx) + int'(rsi);
         1: sum = int'(rbx) + int'(rdi);
         2: sum = int'(rbp) + int'(rsi);
         3: sum = int'(rbp) + int'(rdi);
         4: sum = int'(rsi);
         5: sum = int'(rdi);
         6: sum = (md == 0) ? 0 : int'(rbp);
         default: sum = int'(rbx);
      endcase
      if (md == 0)      dv = (rm == 6) ? int'(d) : 0;
      else if (md == 1) dv = (d[7] ? int'(d[7:0]) - 256 : int'(d[7:0]));
      else              dv = int'(d);
      r.ea = 16'((sum + dv + 262144) % 65536);
      if (oen)                                       r.seg = ov;
      else if (rm == 2 || rm == 3 || (rm == 6 && md != 0)) r.seg = 2'd2;
      else                                           r.seg = 2'd3;
      return r;
   endfunction

   // Drives one request; returns 1ns after the accept edge with start low.
   task automatic drive_req(input logic [7:0] m, input logic [15:0] d, input logic oen,
                            input logic [1:0] ov, input logic [15:0] rbx, input logic [15:0] rbp,
                            input logic [15:0] rsi, input logic [15:0] rdi);
      @(posedge clk); #1;
      modrm = m; disp = d; seg_ovr_en = oen; seg_ovr = ov;
      bx = rbx; bp = rbp; si = rsi; di = rdi;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Counts edges after accept until each instance shows valid; -1 means never within bound.
   task automatic wait_valid(output int c1, output int c0);
      c1 = -1; c0 = -1;
      for (int k = 0; k < 20; k++) begin
         if (valid0 && c0 < 0) c0 = k;
         if (valid1) begin
            c1 = k;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      ack   = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({busy1, valid1, ea1, seg1, is_reg1, reg_sel1} !== {1'b0, 1'b0, 16'h0, 2'd3, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_dut1: busy=%b valid=%b ea=%h seg=%0d is_reg=%b reg_sel=%0d, want 0 0 0000 3 0 0",
                  busy1, valid1, ea1, seg1, is_reg1, reg_sel1);
      end
      vectors++;
      if ({busy0, valid0, ea0, seg0, is_reg0, reg_sel0} !== {1'b0, 1'b0, 16'h0, 2'd3, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_dut0: busy=%b valid=%b ea=%h seg=%0d, want 0 0 0000 3", busy0, valid0, ea0, seg0);
      end
   endtask

   // One directed vector: exact latency on both instances, then result checks.
   task automatic run_directed(input string name, input logic [7:0] m, input logic [15:0] d,
                               input logic oen, input logic [1:0] ov, input logic [15:0] rbx,
                               input logic [15:0] rbp, input logic [15:0] rsi, input logic [15:0] rdi,
                               input logic [15:0] want_ea, input logic [1:0] want_seg);
      int c1, c0;
      drive_req(m, d, oen, ov, rbx, rbp, rsi, rdi);
      vectors++;
      if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
         errors++;
         $display("FAIL %s_accept: busy=%b valid=%b, want 1 0", name, busy1, valid1);
      end
      wait_valid(c1, c0);
      vectors++;
      if (c1 != 2 || c0 != 1) begin
         errors++;
         $display("FAIL %s_latency: stage1=%0d stage0=%0d cycles, want 2 1", name, c1, c0);
      end
      vectors++;
      if (ea1 !== want_ea || seg1 !== want_seg || is_reg1 !== 1'b0) begin
         errors++;
         $display("FAIL %s_result: ea=%h seg=%0d is_reg=%b, want %h %0d 0", name, ea1, seg1, is_reg1, want_ea, want_seg);
      end
      vectors++;
      if (ea0 !== want_ea || seg0 !== want_seg) begin
         errors++;
         $display("FAIL %s_result0: ea=%h seg=%0d, want %h %0d", name, ea0, seg0, want_ea, want_seg);
      end
      do_ack();
      vectors++;
      if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
         errors++;
         $display("FAIL %s_ack: busy=%b valid=%b, want 0 0", name, busy1, valid1);
      end
   endtask

   task automatic test_directed();
      run_directed("bx_si", 8'h00, 16'h0000, 1'b0, 2'd0, 16'h1000, 16'h0, 16'h0034, 16'h0, 16'h1034, 2'd3);
      run_directed("bp_di_d8", 8'h43, 16'h0080, 1'b0, 2'd0, 16'h0, 16'hFFF0, 16'h0, 16'h0020, 16'hFF90, 2'd2);
      run_directed("direct", 8'h06, 16'h1234, 1'b0, 2'd0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1234, 2'd3);
      run_directed("direct_ovr", 8'h06, 16'h1234, 1'b1, 2'd0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1234, 2'd0);
      run_directed("bp_d16", 8'h86, 16'h8001, 1'b0, 2'd0, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0001, 2'd2);
   endtask

   task automatic test_hold();
      int c1, c0;
      drive_req(8'hC5, 16'h5555, 1'b1, 2'd1, 16'h1, 16'h2, 16'h3, 16'h4);
      wait_valid(c1, c0);
      vectors++;
      if (c1 != 2 || is_reg1 !== 1'b1 || reg_sel1 !== 3'd5 || ea1 !== 16'h0 || seg1 !== 2'd3) begin
         errors++;
         $display("FAIL reg_op: lat=%0d is_reg=%b reg_sel=%0d ea=%h seg=%0d, want 2 1 5 0000 3",
                  c1, is_reg1, reg_sel1, ea1, seg1);
      end
      start = 1'b1;
      modrm = 8'h00; bx = 16'hABCD;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         vectors++;
         if (valid1 !== 1'b1 || busy1 !== 1'b1 || is_reg1 !== 1'b1 || reg_sel1 !== 3'd5 || ea1 !== 16'h0) begin
            errors++;
            $display("FAIL hold_%0d: valid=%b busy=%b is_reg=%b reg_sel=%0d ea=%h, want 1 1 1 5 0000",
                     k, valid1, busy1, is_reg1, reg_sel1, ea1);
         end
      end
      start = 1'b0;
      do_ack();
      vectors++;
      if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL hold_ack: valid=%b busy=%b, want 0 0", valid1, busy1);
      end
   endtask

   task automatic test_snapshot();
      int c1, c0;
      drive_req(8'h07, 16'h0, 1'b0, 2'd0, 16'h0100, 16'h0, 16'h0, 16'h0);
      bx = 16'h0200;
      wait_valid(c1, c0);
      vectors++;
      if (c1 < 0 || ea1 !== 16'h0100 || ea0 !== 16'h0100) begin
         errors++;
         $display("FAIL snapshot: lat=%0d ea=%h ea0=%h, want ea 0100", c1, ea1, ea0);
      end
      do_ack();
   endtask

   task automatic test_reset_mid();
      drive_req(8'h00, 16'h0, 1'b0, 2'd0, 16'h1234, 16'h0, 16'h1111, 16'h0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++;
      if ({busy1, valid1, busy0, valid0, ea1, seg1} !== {4'b0000, 16'h0, 2'd3}) begin
         errors++;
         $display("FAIL reset_mid: busy=%b valid=%b busy0=%b valid0=%b ea=%h seg=%0d, want 0 0 0 0 0000 3",
                  busy1, valid1, busy0, valid0, ea1, seg1);
      end
   endtask

   task automatic test_ack_early();
      int c1, c0;
      drive_req(8'h01, 16'h0, 1'b0, 2'd0, 16'h0010, 16'h0, 16'h0, 16'h0005);
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      wait_valid(c1, c0);
      vectors++;
      if (c1 != 1 || ea1 !== 16'h0015 || seg1 !== 2'd3) begin
         errors++;
         $display("FAIL ack_early: lat=%0d ea=%h seg=%0d, want 1 0015 3", c1, ea1, seg1);
      end
      do_ack();
   endtask

   task automatic test_back_to_back();
      int c1, c0;
      drive_req(8'h04, 16'h0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0777, 16'h0);
      wait_valid(c1, c0);
      ack = 1'b1;
      start = 1'b1;
      modrm = 8'h05; di = 16'h0999;
      @(posedge clk); #1;
      ack = 1'b0;
      vectors++;
      if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ack_edge: busy=%b valid=%b, want 0 0", busy1, valid1);
      end
      @(posedge clk); #1;
      start = 1'b0;
      vectors++;
      if (busy1 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b, want 1", busy1);
      end
      wait_valid(c1, c0);
      vectors++;
      if (c1 != 2 || ea1 !== 16'h0999) begin
         errors++;
         $display("FAIL b2b_result: lat=%0d ea=%h, want 2 0999", c1, ea1);
      end
      do_ack();
   endtask

   task automatic test_random();
      int c1, c0;
      exp_t e;
      logic [7:0]  m;
      logic [15:0] d, rbx, rbp, rsi, rdi;
      logic        oen;
      logic [1:0]  ov;
      for (int n = 0; n < 150; n++) begin
         m = 8'($urandom_range(0, 255));
         d = 16'($urandom_range(0, 65535));
         oen = 1'($urandom_range(0, 1));
         ov = 2'($urandom_range(0, 3));
         rbx = 16'($urandom_range(0, 65535));
         rbp = 16'($urandom_range(0, 65535));
         rsi = 16'($urandom_range(0, 65535));
         rdi = 16'($urandom_range(0, 65535));
         e = model(m, d, oen, ov, rbx, rbp, rsi, rdi);
         drive_req(m, d, oen, ov, rbx, rbp, rsi, rdi);
         bx = ~rbx; bp = ~rbp; si = ~rsi; di = ~rdi; disp = ~d;
         wait_valid(c1, c0);
         vectors++;
         if (c1 != 2 || c0 != 1 || ea1 !== e.ea || seg1 !== e.seg || is_reg1 !== e.is_reg ||
             (e.is_reg && reg_sel1 !== e.reg_sel)) begin
            errors++;
            $display("FAIL rand_%0d modrm=%h: lat=%0d/%0d ea=%h seg=%0d is_reg=%b reg_sel=%0d, want 2/1 %h %0d %b %0d",
                     n, m, c1, c0, ea1, seg1, is_reg1, reg_sel1, e.ea, e.seg, e.is_reg, e.reg_sel);
         end
         vectors++;
         if (ea0 !== e.ea || seg0 !== e.seg || is_reg0 !== e.is_reg) begin
            errors++;
            $display("FAIL rand0_%0d modrm=%h: ea=%h seg=%0d is_reg=%b, want %h %0d %b",
                     n, m, ea0, seg0, is_reg0, e.ea, e.seg, e.is_reg);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1 do_ack();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_snapshot();
      test_reset_mid();
      test_ack_early();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
